// File: rtl/i2c_scl_generator.sv
// Runtime-programmable I2C SCL generator with mid-low/mid-high strobes and an end-of-period strobe.
// Define I2C_CLOCK_STRETCH_EN to let a slave hold SCL low and freeze the high phase.
module i2c_scl_generator #(
    parameter int CNT_WIDTH = 21,
    parameter int MIN_HALF  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] half_period,
    input  logic                 scl_in,
    output logic                 scl,
    output logic                 cl_low,
    output logic                 cl_high,
    output logic                 period_done,
    output logic                 busy,
    output logic                 stretching
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    localparam logic [CNT_WIDTH-1:0] MIN_HALF_W = CNT_WIDTH'(MIN_HALF);
    localparam logic [CNT_WIDTH-1:0] ONE_W      = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_stateNext;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cntNext;
    logic [CNT_WIDTH-1:0] r_hpQ;
    logic [CNT_WIDTH-1:0] w_hpNext;
    logic [CNT_WIDTH-1:0] w_hpClamped;
    logic                 r_scl;
    logic                 r_busy;
    logic                 r_clLow;
    logic                 r_clHigh;
    logic                 w_clLowNext;
    logic                 w_clHighNext;
    logic                 w_lastCycle;
    logic                 w_quarter;
    logic                 w_hold;

`ifdef I2C_CLOCK_STRETCH_EN
    logic r_sync1;
    logic r_sclSync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sclSync <= 1'b1;
        end else begin
            r_sync1   <= scl_in;
            r_sclSync <= r_sync1;
        end
    end

    assign w_hold = (r_state == HIGH) && !r_sclSync;
`else
    logic w_unusedSclIn;
    assign w_unusedSclIn = scl_in;
    assign w_hold        = 1'b0;
`endif

    assign w_hpClamped = (half_period < MIN_HALF_W) ? MIN_HALF_W : half_period;
    assign w_lastCycle = (r_cnt == r_hpQ - ONE_W);
    assign w_quarter   = (r_cnt == (r_hpQ >> 1) - ONE_W);

    // Strobes are computed one cycle early so the registered pulse lands at cnt == hp_q/2.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_hpNext     = r_hpQ;
        w_clLowNext  = 1'b0;
        w_clHighNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_stateNext = LOW;
                    w_cntNext   = '0;
                    w_hpNext    = w_hpClamped;
                end
            end
            LOW: begin
                w_cntNext   = r_cnt + ONE_W;
                w_clLowNext = w_quarter;
                if (w_lastCycle) begin
                    w_stateNext = HIGH;
                    w_cntNext   = '0;
                end
            end
            HIGH: begin
                if (!w_hold) begin
                    w_cntNext    = r_cnt + ONE_W;
                    w_clHighNext = w_quarter;
                    if (w_lastCycle) begin
                        w_cntNext = '0;
                        if (enable) begin
                            w_stateNext = LOW;
                            w_hpNext    = w_hpClamped;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hpQ    <= MIN_HALF_W;
            r_scl    <= 1'b1;
            r_busy   <= 1'b0;
            r_clLow  <= 1'b0;
            r_clHigh <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_hpQ    <= w_hpNext;
            r_scl    <= (w_stateNext != LOW);
            r_busy   <= (w_stateNext != IDLE);
            r_clLow  <= w_clLowNext;
            r_clHigh <= w_clHighNext;
        end
    end

    assign scl         = r_scl;
    assign busy        = r_busy;
    assign cl_low      = r_clLow;
    assign cl_high     = r_clHigh;
    assign period_done = (r_state == HIGH) && w_lastCycle && !w_hold;
    assign stretching  = w_hold;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Self-checking bench for i2c_scl_generator (default build, clock stretching disabled).
// A per-period waveform model fills a queue of expected cycles whenever a new period is latched.
module tb_i2c_scl_generator;

    localparam int CW = 21;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] halfPeriod = '0;
    logic          sclIn = 1'b1;
    logic          scl, clLow, clHigh, periodDone, busy, stretching;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic scl;
        logic clLow;
        logic clHigh;
        logic periodDone;
        logic busy;
    } exp_t;

    exp_t expQ[$];

    i2c_scl_generator #(.CNT_WIDTH(CW), .MIN_HALF(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .half_period (halfPeriod),
        .scl_in      (sclIn),
        .scl         (scl),
        .cl_low      (clLow),
        .cl_high     (clHigh),
        .period_done (periodDone),
        .busy        (busy),
        .stretching  (stretching)
    );

    always #5 clock = ~clock;

    task automatic checkOne(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s at %0t: observed=%b expected=%b", tag, $time, observed, expected);
        end
    endtask

    // Compares the current cycle against the model; an empty queue means the DUT should be idle.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() > 0) e = expQ.pop_front();
        else e = '{scl: 1'b1, clLow: 1'b0, clHigh: 1'b0, periodDone: 1'b0, busy: 1'b0};
        checkOne("scl", scl, e.scl);
        checkOne("cl_low", clLow, e.clLow);
        checkOne("cl_high", clHigh, e.clHigh);
        checkOne("period_done", periodDone, e.periodDone);
        checkOne("busy", busy, e.busy);
        checkOne("stretching", stretching, 1'b0);
    endtask

    // A whole period of 2*hp cycles: low half, high half, strobes at the middle of each half.
    task automatic pushPeriod(input int hpRaw);
        int hp;
        exp_t e;
        hp = (hpRaw < 2) ? 2 : hpRaw;
        for (int i = 0; i < 2 * hp; i++) begin
            e.scl        = (i >= hp);
            e.clLow      = (i == hp / 2);
            e.clHigh     = (i == hp + hp / 2);
            e.periodDone = (i == 2 * hp - 1);
            e.busy       = 1'b1;
            expQ.push_back(e);
        end
    endtask

    // Drives inputs for the next edge; the model starts a period only when the DUT is at a latch point.
    task automatic applyStimulus(input logic en, input int hp, input logic rst, input logic sIn);
        enable     = en;
        halfPeriod = CW'(hp);
        reset      = rst;
        sclIn      = sIn;
        if (rst) expQ.delete();
        else if (expQ.size() == 0 && en) pushPeriod(hp);
    endtask

    task automatic step(input logic en, input int hp, input logic rst);
        checkOutput();
        applyStimulus(en, hp, rst, 1'($urandom_range(0, 1)));
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        $display("[TB] reset state");
        step(1'b0, 4, 1'b1);
        step(1'b0, 4, 1'b0);

        $display("[TB] half_period=4 continuous");
        for (int i = 0; i < 24; i++) step(1'b1, 4, 1'b0);

        $display("[TB] clamped half periods");
        for (int i = 0; i < 12; i++) step(1'b1, 0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1, 1'b0);
        for (int i = 0; i < 4; i++)  step(1'b0, 1, 1'b0);

        $display("[TB] half_period change mid-LOW");
        step(1'b1, 4, 1'b0);
        step(1'b1, 4, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 6, 1'b0);

        $display("[TB] enable dropped mid-period");
        for (int i = 0; i < 3; i++)  step(1'b1, 5, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 5, 1'b0);

        $display("[TB] reset mid-HIGH then restart");
        for (int i = 0; i < 6; i++)  step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 3, 1'b0);

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            int hp;
            logic en;
            logic rst;
            hp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 9));
            en  = ($urandom_range(0, 9) < 8);
            rst = ($urandom_range(0, 199) == 0);
            step(en, hp, rst);
        end
        for (int i = 0; i < 24; i++) step(1'b0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
